// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch squash,
// data-memory wait freeze with timeout, and saturating stall/flush counters.
module hazard_stall_unit #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_RegRt,
  input  logic [4:0]       IFID_RegRs,
  input  logic [4:0]       IFID_RegRt,
  input  logic             IFID_UsesRt,
  input  logic             IFID_IsStore,
  input  logic             BranchTaken,
  input  logic             DMem_Req,
  input  logic             DMem_Ready,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             PipeHold,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

  state_e           stateQ, stateD;
  logic [WaitW-1:0] waitCntQ, waitCntD;
  logic             timeoutQ, timeoutD;
  logic [CNT_W-1:0] stallCntQ, flushCntQ;

  logic memWait, matchRs, matchRt, loadUse;

  assign memWait = DMem_Req & ~DMem_Ready;
  assign matchRs = (IDEX_RegRt == IFID_RegRs);
  // Store data on rt is handled by WB->MEM forwarding, so it never stalls.
  assign matchRt = IFID_UsesRt & ~IFID_IsStore & (IDEX_RegRt == IFID_RegRt);
  assign loadUse = IDEX_MemRead & (IDEX_RegRt != 5'd0) & (matchRs | matchRt);

  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    PipeHold    = 1'b0;
    if (!rst_n) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (stateQ == StError || memWait) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      PipeHold  = 1'b1;
    end else if (BranchTaken) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (loadUse) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEX_Bubble = 1'b1;
    end
  end

  always_comb begin
    stateD   = stateQ;
    waitCntD = waitCntQ;
    timeoutD = timeoutQ;
    unique case (stateQ)
      StRun: begin
        if (memWait) begin
          stateD   = StMemWait;
          waitCntD = WaitW'(1);
        end
      end
      StMemWait: begin
        if (DMem_Ready || !DMem_Req) begin
          // Completion or aborted access both release the pipeline.
          stateD   = StRun;
          waitCntD = '0;
        end else if (waitCntQ == WaitLast) begin
          stateD   = StError;
          timeoutD = 1'b1;
        end else begin
          waitCntD = waitCntQ + WaitW'(1);
        end
      end
      StError: stateD = StError;
      default: stateD = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ    <= StRun;
      waitCntQ  <= '0;
      timeoutQ  <= 1'b0;
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
      timeoutQ <= timeoutD;
      if (!PCWrite && stallCntQ != '1) stallCntQ <= stallCntQ + CNT_W'(1);
      if (IFID_Flush && flushCntQ != '1) flushCntQ <= flushCntQ + CNT_W'(1);
    end
  end

  assign MemTimeout = timeoutQ;
  assign StallCount = stallCntQ;
  assign FlushCount = flushCntQ;

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage MIPS32 pipeline; complements the forwarding unit.
- Covers the hazards forwarding cannot resolve:
  - load-use dependencies, by inserting one bubble;
  - taken-branch squash;
  - multi-cycle data-memory waits, by freezing the whole pipeline.
- Also maintains a memory-wait timeout and saturating performance counters.
- Sits in the ID stage. Drives the PC, IF/ID and ID/EX write/flush controls and a global pipeline hold.

Parameters:
- CNT_W, 32, width of StallCount and FlushCount.
- MAX_WAIT, 16, maximum consecutive memory-wait cycles before MemTimeout (>=2).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- IDEX_MemRead  input  1  instruction in EX is a load.
- IDEX_RegRt  input  5  load destination register.
- IFID_RegRs  input  5  rs of instruction in ID.
- IFID_RegRt  input  5  rt of instruction in ID.
- IFID_UsesRt  input  1  ID instruction reads rt as an ALU operand.
- IFID_IsStore  input  1  ID instruction is a store (rt is store data only).
- BranchTaken  input  1  branch resolved taken this cycle.
- DMem_Req  input  1  MEM stage has an access in progress.
- DMem_Ready  input  1  data memory completes the access this cycle.
- PCWrite  output  1  PC load enable.
- IFIDWrite  output  1  IF/ID register load enable.
- IFID_Flush  output  1  zero IF/ID on next edge.
- IDEX_Bubble  output  1  load a NOP into ID/EX on next edge.
- PipeHold  output  1  freeze ID/EX, EX/MEM, MEM/WB.
- MemTimeout  output  1  sticky error flag.
- StallCount  output  CNT_W  cycles with PCWrite=0.
- FlushCount  output  CNT_W  branch flushes executed.

Behaviour:
- Registered state: FSM {RUN, MEM_WAIT, ERROR}, wait counter (ceil(log2 MAX_WAIT) bits), StallCount, FlushCount, MemTimeout.
- Control outputs are combinational from state and current inputs.
- Reset: when rst_n=0 at an edge, state goes to RUN, wait counter=0, counters=0 and MemTimeout=0.
  - While rst_n=0, outputs are forced: PCWrite=0, IFIDWrite=0, IFID_Flush=1, IDEX_Bubble=1, PipeHold=0.
  - Counters do not increment during reset.
- memwait = DMem_Req & !DMem_Ready.
- Hazard terms:
  - match_rs = IDEX_RegRt==IFID_RegRs.
  - match_rt = IFID_UsesRt & !IFID_IsStore & IDEX_RegRt==IFID_RegRt.
  - loaduse = IDEX_MemRead & IDEX_RegRt!=0 & (match_rs | match_rt).
  - A store whose only dependence is on rt does not stall; that case is covered by WB->MEM store-data forwarding.
- Priority, highest first: ERROR, memwait, BranchTaken, loaduse, normal.
  - ERROR or memwait: PipeHold=1, PCWrite=0, IFIDWrite=0, IFID_Flush=0, IDEX_Bubble=0. A pending BranchTaken or loaduse is deferred; inputs stay stable because the pipeline is frozen.
  - BranchTaken: PCWrite=1, IFIDWrite=1, IFID_Flush=1, IDEX_Bubble=1, PipeHold=0. loaduse is ignored because the ID instruction is squashed.
  - loaduse: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, others 0. The hazard clears on the next cycle because the load advances.
  - Normal: PCWrite=1, IFIDWrite=1, others 0.
- FSM transitions:
  - RUN->MEM_WAIT on memwait; wait counter=1.
  - MEM_WAIT, DMem_Ready=1: go to RUN and clear the wait counter. In that same cycle PipeHold=0 and the lower-priority rules apply.
  - MEM_WAIT, memwait and counter==MAX_WAIT-1: go to ERROR and set MemTimeout.
  - MEM_WAIT, memwait otherwise: increment the counter.
  - MEM_WAIT, DMem_Req drops without DMem_Ready (aborted access): go to RUN.
  - ERROR: held until reset.
- StallCount: +1 each non-reset cycle with PCWrite=0; saturates at all-ones.
- FlushCount: +1 each non-reset cycle with IFID_Flush=1; saturates at all-ones.

Test Plan:
- Load-use on rs: IDEX_MemRead=1, IDEX_RegRt=5, IFID_RegRs=5 -> one cycle of PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; next cycle (MemRead=0) normal; StallCount=1.
- Register zero and store-data cases:
  - IDEX_RegRt=0 matching rs -> no stall.
  - IFID_IsStore=1, IFID_UsesRt=1, IFID_RegRt=7=IDEX_RegRt, rs differs -> no stall.
- Branch vs load-use: BranchTaken=1 with loaduse true -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1; FlushCount=1; StallCount unchanged.
- Memory wait: DMem_Req=1, DMem_Ready=0 for 3 cycles, then Ready=1 -> PipeHold=1 for 3 cycles, released in the Ready cycle; StallCount=3. A BranchTaken held throughout is acted on only in the Ready cycle.
- Timeout (MAX_WAIT=4): DMem_Ready never asserts -> MemTimeout=1 after the 4th wait cycle; PipeHold remains 1; rst_n=0 for one edge clears everything and forces the reset output values.
- Saturation (CNT_W=4): 20 load-use stalls -> StallCount=15 and stays at 15.
